// File: rtl/dual_issue_splitter.sv
// Purpose: splits a fetched instruction pair into two decode issue slots.
// Latency: a pair accepted at edge N is on the slots after edge N; a hazard pair drains over 2 cycles.
// Backpressure: in_ready drops while a split pair drains, while decode stalls, or on flush.
// Build option: define DUAL_ISSUE_PERF_EN to add pair_cnt/split_cnt performance counters.
module dual_issue_splitter #(
  parameter int XLEN      = 32,
  parameter int MEM_SPLIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] InstrD1,
  input  logic [XLEN-1:0] InstrD2,
  input  logic [XLEN-1:0] PCD1,
  input  logic [XLEN-1:0] PCD2,
  input  logic [XLEN-1:0] PCPlus4D1,
  input  logic [XLEN-1:0] PCPlus4D2,
  input  logic            issue_ready,
  output logic            slot0_valid,
  output logic            slot1_valid,
  output logic [XLEN-1:0] slot0_instr,
  output logic [XLEN-1:0] slot0_pc,
  output logic [XLEN-1:0] slot0_pcplus4,
  output logic [XLEN-1:0] slot1_instr,
  output logic [XLEN-1:0] slot1_pc,
  output logic [XLEN-1:0] slot1_pcplus4,
  output logic            split
`ifdef DUAL_ISSUE_PERF_EN
  ,
  output logic [31:0]     pair_cnt,
  output logic [31:0]     split_cnt
`endif
);

  // RV32 major opcodes that matter for intra-pair hazards
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_PAIR   = 2'd1,
    ST_SECOND = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] instr1_q, pc1_q, pc4_1_q;
  logic [XLEN-1:0] instr2_q, pc2_q, pc4_2_q;

  logic            load_pair;
  logic            conflict;
  logic            raw_hit;
  logic            ctrl_hit;
  logic            mem_hit;

  logic [6:0]      op1, op2;
  logic [4:0]      rd1, rs1_2, rs2_2;

  function automatic logic op_writes_rd(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

  function automatic logic op_reads_rs1(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JALR: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  function automatic logic op_reads_rs2(input logic [6:0] op);
    case (op)
      OP_R, OP_STORE, OP_BR: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_ctrl(input logic [6:0] op);
    case (op)
      OP_BR, OP_JAL, OP_JALR: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Hazard check on the buffered pair: lane 2 may not issue alongside lane 1
  always_comb begin
    op1      = instr1_q[6:0];
    op2      = instr2_q[6:0];
    rd1      = instr1_q[11:7];
    rs1_2    = instr2_q[19:15];
    rs2_2    = instr2_q[24:20];
    raw_hit  = op_writes_rd(op1) && (rd1 != 5'd0) &&
               ((op_reads_rs1(op2) && (rs1_2 == rd1)) ||
                (op_reads_rs2(op2) && (rs2_2 == rd1)));
    ctrl_hit = op_is_ctrl(op1);
    mem_hit  = (MEM_SPLIT != 0) && op_is_mem(op1) && op_is_mem(op2);
    conflict = raw_hit || ctrl_hit || mem_hit;
  end

  // Fetch handshake: accept only when the buffer will be empty after this edge
  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_EMPTY:  in_ready = 1'b1;
        ST_PAIR:   in_ready = issue_ready && !conflict;
        ST_SECOND: in_ready = issue_ready;
        default:   in_ready = 1'b0;
      endcase
    end
    load_pair = in_valid && in_ready;
  end

  // Next-state: flush wins, otherwise advance only when decode consumes
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid) state_d = ST_PAIR;
        end
        ST_PAIR: begin
          if (issue_ready) begin
            if (conflict)      state_d = ST_SECOND;
            else if (in_valid) state_d = ST_PAIR;
            else               state_d = ST_EMPTY;
          end
        end
        ST_SECOND: begin
          if (issue_ready) state_d = in_valid ? ST_PAIR : ST_EMPTY;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and pair buffer; lane 2 stays put in SECOND so it can be presented on slot 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      instr1_q <= '0;
      pc1_q    <= '0;
      pc4_1_q  <= '0;
      instr2_q <= '0;
      pc2_q    <= '0;
      pc4_2_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_pair) begin
        instr1_q <= InstrD1;
        pc1_q    <= PCD1;
        pc4_1_q  <= PCPlus4D1;
        instr2_q <= InstrD2;
        pc2_q    <= PCD2;
        pc4_2_q  <= PCPlus4D2;
      end
    end
  end

  // Slot steering: oldest live instruction always goes to slot 0, dead fields read 0
  always_comb begin
    slot0_valid   = 1'b0;
    slot1_valid   = 1'b0;
    slot0_instr   = '0;
    slot0_pc      = '0;
    slot0_pcplus4 = '0;
    slot1_instr   = '0;
    slot1_pc      = '0;
    slot1_pcplus4 = '0;
    split         = 1'b0;
    case (state_q)
      ST_PAIR: begin
        slot0_valid   = 1'b1;
        slot0_instr   = instr1_q;
        slot0_pc      = pc1_q;
        slot0_pcplus4 = pc4_1_q;
        split         = conflict;
        if (!conflict) begin
          slot1_valid   = 1'b1;
          slot1_instr   = instr2_q;
          slot1_pc      = pc2_q;
          slot1_pcplus4 = pc4_2_q;
        end
      end
      ST_SECOND: begin
        slot0_valid   = 1'b1;
        slot0_instr   = instr2_q;
        slot0_pc      = pc2_q;
        slot0_pcplus4 = pc4_2_q;
      end
      default: ;
    endcase
  end

`ifdef DUAL_ISSUE_PERF_EN
  logic [31:0] pair_cnt_q, pair_cnt_d;
  logic [31:0] split_cnt_q, split_cnt_d;

  // Count pairs leaving PAIR whole versus split; counters wrap naturally
  always_comb begin
    pair_cnt_d  = pair_cnt_q;
    split_cnt_d = split_cnt_q;
    if ((state_q == ST_PAIR) && issue_ready && !flush) begin
      if (conflict) split_cnt_d = split_cnt_q + 32'd1;
      else          pair_cnt_d  = pair_cnt_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pair_cnt_q  <= '0;
      split_cnt_q <= '0;
    end else begin
      pair_cnt_q  <= pair_cnt_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign pair_cnt  = pair_cnt_q;
  assign split_cnt = split_cnt_q;
`endif

endmodule

// File: tb/tb_dual_issue_splitter.sv
// Bench for dual_issue_splitter: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-level reference model, on MEM_SPLIT=1 and MEM_SPLIT=0 instances.
module tb_dual_issue_splitter;

  localparam int VW = 196;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, issue_ready;
  logic [31:0] InstrD1, InstrD2, PCD1, PCD2, PCPlus4D1, PCPlus4D2;

  logic        rdy_a, s0v_a, s1v_a, sp_a;
  logic [31:0] s0i_a, s0p_a, s0p4_a, s1i_a, s1p_a, s1p4_a;
  logic        rdy_b, s0v_b, s1v_b, sp_b;
  logic [31:0] s0i_b, s0p_b, s0p4_b, s1i_b, s1p_b, s1p4_b;
`ifdef DUAL_ISSUE_PERF_EN
  logic [31:0] pc_a, sc_a, pc_b, sc_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // a: MEM_SPLIT=1, b: MEM_SPLIT=0
  dual_issue_splitter #(.XLEN(32), .MEM_SPLIT(1)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .InstrD1(InstrD1), .InstrD2(InstrD2), .PCD1(PCD1), .PCD2(PCD2),
    .PCPlus4D1(PCPlus4D1), .PCPlus4D2(PCPlus4D2), .issue_ready(issue_ready),
    .slot0_valid(s0v_a), .slot1_valid(s1v_a),
    .slot0_instr(s0i_a), .slot0_pc(s0p_a), .slot0_pcplus4(s0p4_a),
    .slot1_instr(s1i_a), .slot1_pc(s1p_a), .slot1_pcplus4(s1p4_a),
    .split(sp_a)
`ifdef DUAL_ISSUE_PERF_EN
    , .pair_cnt(pc_a), .split_cnt(sc_a)
`endif
  );

  dual_issue_splitter #(.XLEN(32), .MEM_SPLIT(0)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .InstrD1(InstrD1), .InstrD2(InstrD2), .PCD1(PCD1), .PCD2(PCD2),
    .PCPlus4D1(PCPlus4D1), .PCPlus4D2(PCPlus4D2), .issue_ready(issue_ready),
    .slot0_valid(s0v_b), .slot1_valid(s1v_b),
    .slot0_instr(s0i_b), .slot0_pc(s0p_b), .slot0_pcplus4(s0p4_b),
    .slot1_instr(s1i_b), .slot1_pc(s1p_b), .slot1_pcplus4(s1p4_b),
    .split(sp_b)
`ifdef DUAL_ISSUE_PERF_EN
    , .pair_cnt(pc_b), .split_cnt(sc_b)
`endif
  );

  wire [VW-1:0] got_a = {rdy_a, s0v_a, s1v_a, sp_a, s0i_a, s0p_a, s0p4_a, s1i_a, s1p_a, s1p4_a};
  wire [VW-1:0] got_b = {rdy_b, s0v_b, s1v_b, sp_b, s0i_b, s0p_b, s0p4_b, s1i_b, s1p_b, s1p4_b};

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // Expected output vector; pc+4 fields follow the driver convention pc+4 on valid slots
  function automatic logic [VW-1:0] mkvec(input logic rdy, input logic v0, input logic v1, input logic sp,
                                          input logic [31:0] i0, input logic [31:0] p0,
                                          input logic [31:0] i1, input logic [31:0] p1);
    logic [31:0] q0, q1;
    q0 = v0 ? p0 + 32'd4 : 32'd0;
    q1 = v1 ? p1 + 32'd4 : 32'd0;
    return {rdy, v0, v1, sp, i0, p0, q0, i1, p1, q1};
  endfunction

  task automatic drive(input logic r, input logic f, input logic v,
                       input logic [31:0] i1, input logic [31:0] i2, input logic ir);
    rst = r; flush = f; in_valid = v; issue_ready = ir;
    InstrD1 = i1; InstrD2 = i2;
    PCD1 = 32'h100; PCD2 = 32'h104; PCPlus4D1 = 32'h104; PCPlus4D2 = 32'h108;
  endtask

  // ---------------- directed vector table (MEM_SPLIT=1 instance) ----------------
  typedef struct {
    logic r, f, v, ir;
    logic [31:0] i1, i2;
    logic rdy, v0, v1, sp;
    logic [31:0] e_i0, e_p0, e_i1, e_p1;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic f, input logic v, input logic [31:0] i1, input logic [31:0] i2,
                     input logic ir, input logic rdy, input logic v0, input logic v1, input logic sp,
                     input logic [31:0] e_i0, input logic [31:0] e_p0, input logic [31:0] e_i1, input logic [31:0] e_p1);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.ir = ir; t.i1 = i1; t.i2 = i2;
    t.rdy = rdy; t.v0 = v0; t.v1 = v1; t.sp = sp;
    t.e_i0 = e_i0; t.e_p0 = e_p0; t.e_i1 = e_i1; t.e_p1 = e_p1;
    tbl.push_back(t);
  endtask

  // ---------------- reference model: a queue of held instructions ----------------
  int          m_cnt [2];
  logic [31:0] m_i [2][2];
  logic [31:0] m_p [2][2];
  logic [31:0] m_p4[2][2];

  function automatic logic ref_conflict(input logic [31:0] a, input logic [31:0] b, input bit ms);
    logic [6:0] oa, ob;
    logic wr, r1, r2, ctl, ma, mb;
    oa  = a[6:0]; ob = b[6:0];
    wr  = oa inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    r1  = ob inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    r2  = ob inside {7'b0110011, 7'b0100011, 7'b1100011};
    ctl = oa inside {7'b1100011, 7'b1101111, 7'b1100111};
    ma  = oa inside {7'b0000011, 7'b0100011};
    mb  = ob inside {7'b0000011, 7'b0100011};
    return (wr && a[11:7] != 5'd0 && ((r1 && b[19:15] == a[11:7]) || (r2 && b[24:20] == a[11:7])))
           || ctl || (ms && ma && mb);
  endfunction

  // How many held instructions decode takes this cycle
  function automatic int ref_take(input int d);
    if (!issue_ready || m_cnt[d] == 0) return 0;
    if (m_cnt[d] == 1) return 1;
    return ref_conflict(m_i[d][0], m_i[d][1], d == 0) ? 1 : 2;
  endfunction

  function automatic logic [VW-1:0] ref_out(input int d);
    logic c, rdy;
    rdy = !flush && (m_cnt[d] - ref_take(d) == 0);
    if (m_cnt[d] == 0) return {rdy, 195'd0};
    if (m_cnt[d] == 1) return {rdy, 3'b100, m_i[d][0], m_p[d][0], m_p4[d][0], 96'd0};
    c = ref_conflict(m_i[d][0], m_i[d][1], d == 0);
    if (c) return {rdy, 3'b101, m_i[d][0], m_p[d][0], m_p4[d][0], 96'd0};
    return {rdy, 3'b110, m_i[d][0], m_p[d][0], m_p4[d][0], m_i[d][1], m_p[d][1], m_p4[d][1]};
  endfunction

  task automatic ref_step(input int d);
    int  tk;
    logic rdy;
    tk  = ref_take(d);
    rdy = !flush && (m_cnt[d] - tk == 0);
    if (!rst || flush) begin
      m_cnt[d] = 0;
    end else begin
      if (tk == 1 && m_cnt[d] == 2) begin
        m_i[d][0] = m_i[d][1]; m_p[d][0] = m_p[d][1]; m_p4[d][0] = m_p4[d][1];
      end
      m_cnt[d] = m_cnt[d] - tk;
      if (in_valid && rdy) begin
        m_cnt[d] = 2;
        m_i[d][0] = InstrD1; m_p[d][0] = PCD1; m_p4[d][0] = PCPlus4D1;
        m_i[d][1] = InstrD2; m_p[d][1] = PCD2; m_p4[d][1] = PCPlus4D2;
      end
    end
  endtask

  // Random instruction biased towards hazards: few registers, mostly hazard-relevant opcodes
  function automatic logic [31:0] rand_instr();
    logic [6:0] op, f7;
    logic [4:0] rs2, rs1, rd;
    logic [2:0] f3;
    case ($urandom_range(0, 9))
      0: op = 7'b0110011;  1: op = 7'b0010011;  2: op = 7'b0000011;
      3: op = 7'b0100011;  4: op = 7'b0110111;  5: op = 7'b0010111;
      6: op = 7'b1101111;  7: op = 7'b1100111;  8: op = 7'b1100011;
      default: op = 7'b1110011;
    endcase
    f7  = 7'($urandom_range(0, 127));
    rs2 = 5'($urandom_range(0, 3));
    rs1 = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 3));
    f3  = 3'($urandom_range(0, 7));
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  localparam logic [31:0] IA  = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] IB  = 32'h00700193;  // addi x3,x0,7
  localparam logic [31:0] IC  = 32'h00108133;  // add  x2,x1,x1
  localparam logic [31:0] ID  = 32'h00108013;  // addi x0,x1,1
  localparam logic [31:0] IE  = 32'h00000133;  // add  x2,x0,x0
  localparam logic [31:0] IL1 = 32'h00002283;  // lw x5,0(x0)
  localparam logic [31:0] IL2 = 32'h00402303;  // lw x6,4(x0)
  localparam logic [31:0] IBQ = 32'h00000463;  // beq x0,x0,8

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    //  r  f  v  i1   i2   ir   rdy v0 v1 sp  e_i0  e_p0    e_i1 e_p1
    add(0, 0, 0, 0,   0,   1,   1,  0, 0, 0,  0,    0,      0,   0);      // reset state
    add(1, 0, 1, IA,  IB,  1,   1,  0, 0, 0,  0,    0,      0,   0);      // load independent pair
    add(1, 0, 0, 0,   0,   1,   1,  1, 1, 0,  IA,   'h100,  IB,  'h104);  // both slots
    add(1, 0, 1, IA,  IC,  1,   1,  0, 0, 0,  0,    0,      0,   0);      // load RAW pair
    add(1, 0, 0, 0,   0,   1,   0,  1, 0, 1,  IA,   'h100,  0,   0);      // split, lane 1
    add(1, 0, 0, 0,   0,   1,   1,  1, 0, 0,  IC,   'h104,  0,   0);      // lane 2 alone
    add(1, 0, 1, ID,  IE,  1,   1,  0, 0, 0,  0,    0,      0,   0);      // load x0 pair
    add(1, 0, 0, 0,   0,   1,   1,  1, 1, 0,  ID,   'h100,  IE,  'h104);  // no split for x0
    add(1, 0, 1, IL1, IL2, 1,   1,  0, 0, 0,  0,    0,      0,   0);      // load two lw
    add(1, 0, 0, 0,   0,   1,   0,  1, 0, 1,  IL1,  'h100,  0,   0);      // mem split
    add(1, 0, 1, IBQ, IB,  1,   1,  1, 0, 0,  IL2,  'h104,  0,   0);      // SECOND + load beq pair
    add(1, 0, 0, 0,   0,   1,   0,  1, 0, 1,  IBQ,  'h100,  0,   0);      // branch split
    add(1, 1, 1, IA,  IB,  0,   0,  1, 0, 0,  IB,   'h104,  0,   0);      // flush in SECOND
    add(1, 0, 0, 0,   0,   1,   1,  0, 0, 0,  0,    0,      0,   0);      // lane 2 killed
    add(1, 0, 1, IA,  IB,  1,   1,  0, 0, 0,  0,    0,      0,   0);      // load
    add(1, 0, 1, IA,  IC,  0,   0,  1, 1, 0,  IA,   'h100,  IB,  'h104);  // stall 1
    add(1, 0, 1, IA,  IC,  0,   0,  1, 1, 0,  IA,   'h100,  IB,  'h104);  // stall 2
    add(1, 0, 1, IA,  IC,  0,   0,  1, 1, 0,  IA,   'h100,  IB,  'h104);  // stall 3
    add(1, 0, 0, 0,   0,   1,   1,  1, 1, 0,  IA,   'h100,  IB,  'h104);  // release
    add(1, 0, 1, IA,  IC,  1,   1,  0, 0, 0,  0,    0,      0,   0);      // load RAW pair
    add(1, 0, 0, 0,   0,   1,   0,  1, 0, 1,  IA,   'h100,  0,   0);      // split
    add(0, 1, 1, IA,  IB,  1,   0,  1, 0, 0,  IC,   'h104,  0,   0);      // reset in SECOND
    add(1, 0, 0, 0,   0,   0,   1,  0, 0, 0,  0,    0,      0,   0);      // cleared by reset
    add(1, 0, 1, IA,  IB,  1,   1,  0, 0, 0,  0,    0,      0,   0);      // load
    add(1, 0, 1, ID,  IE,  1,   1,  1, 1, 0,  IA,   'h100,  IB,  'h104);  // back-to-back reload
    add(1, 0, 0, 0,   0,   1,   1,  1, 1, 0,  ID,   'h100,  IE,  'h104);  // second pair

    foreach (tbl[k]) begin
      drive(tbl[k].r, tbl[k].f, tbl[k].v, tbl[k].i1, tbl[k].i2, tbl[k].ir);
      @(negedge clk);
      check($sformatf("table[%0d]", k), got_a,
            mkvec(tbl[k].rdy, tbl[k].v0, tbl[k].v1, tbl[k].sp,
                  tbl[k].e_i0, tbl[k].e_p0, tbl[k].e_i1, tbl[k].e_p1));
      @(posedge clk);
      #1;
    end

    // Two loads: split on MEM_SPLIT=1, issued together on MEM_SPLIT=0
    drive(1'b1, 1'b0, 1'b1, IL1, IL2, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    check("lw_pair_nosplit", got_b, mkvec(1, 1, 1, 0, IL1, 'h100, IL2, 'h104));
    check("lw_pair_split",   got_a, mkvec(0, 1, 0, 1, IL1, 'h100, 0, 0));
    @(posedge clk); #1;
    @(negedge clk);
    check("lw_pair_nosplit_done", got_b, mkvec(1, 0, 0, 0, 0, 0, 0, 0));
    check("lw_pair_split_lane2",  got_a, mkvec(1, 1, 0, 0, IL2, 'h104, 0, 0));
    @(posedge clk); #1;

    // Randomized traffic against the queue model
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst         = ($urandom_range(0, 59) != 0);
      flush       = ($urandom_range(0, 11) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      issue_ready = ($urandom_range(0, 2) != 0);
      InstrD1     = rand_instr();
      InstrD2     = rand_instr();
      PCD1        = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      PCD2        = PCD1 + 32'd4;
      PCPlus4D1   = PCD1 + 32'd4;
      PCPlus4D2   = PCD2 + 32'd4;
      @(negedge clk);
      check("rand_memsplit1", got_a, ref_out(0));
      check("rand_memsplit0", got_b, ref_out(1));
      @(posedge clk);
      ref_step(0);
      ref_step(1);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
